vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches (2-cycle read pipeline) versus a CPU read/write port.
// Optional CPU anti-starvation override enabled by defining VRAM_CPU_STARVE_EN.
module vram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic        vid_miss,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RDATA,
    S_ACK
  } cpu_state_t;

  cpu_state_t  state, state_nxt;
  logic        override;
  logic        vid_grant;
  logic        cpu_grant;
  logic [15:0] last_addr;
  logic        p1_valid;

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("vram_arbiter: STARVE_LIMIT must be in 1..15");
  end

`ifdef VRAM_CPU_STARVE_EN
  logic [3:0] starve_cnt;
  logic       p1_miss;

  // Counter never passes the limit: reaching it forces a CPU grant, which clears it.
  always_comb override = (state == S_WAIT) && (starve_cnt >= 4'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      p1_miss    <= 1'b0;
      vid_miss   <= 1'b0;
    end else begin
      if (cpu_grant)
        starve_cnt <= '0;
      else if (state == S_WAIT)
        starve_cnt <= starve_cnt + 4'd1;
      p1_miss  <= vid_req && override;
      vid_miss <= p1_miss;
    end
  end
`else
  always_comb override = 1'b0;
  always_comb vid_miss = 1'b0;
`endif

  always_comb begin
    vid_grant = vid_req && !override && !reset;
    cpu_grant = (state == S_WAIT) && (!vid_req || override) && !reset;
  end

  // RAM command; an idle cycle keeps the previous address on the bus.
  always_comb begin
    mem_addr  = last_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vid_grant) begin
      mem_addr = vid_addr;
    end else if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_ack   = 1'b0;
    case (state)
      S_IDLE:  if (cpu_req) state_nxt = S_WAIT;
      S_WAIT:  if (cpu_grant) state_nxt = cpu_we ? S_ACK : S_RDATA;
      S_RDATA: state_nxt = S_ACK;
      S_ACK: begin
        cpu_ack   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      last_addr <= '0;
      p1_valid  <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_nxt;
      last_addr <= mem_addr;
      p1_valid  <= vid_grant;
      vid_valid <= p1_valid;
      if (p1_valid)
        vid_data <= mem_rdata;
      if (state == S_RDATA)
        cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: cycle-level reference model plus directed scenarios with literal expectations.
// Build with VRAM_CPU_STARVE_EN defined to exercise the starvation override instead of strict priority.
module tb_vram_arbiter;

  localparam int unsigned LIMIT = 8;
`ifdef VRAM_CPU_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        vid_miss;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous read-first RAM, each byte initialised to its low address byte.
  logic [7:0] ram   [0:65535];
  logic [7:0] m_ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]   = 8'(i);
      m_ram[i] = 8'(i);
    end
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         valid;
    bit         miss;
    logic [7:0] data;
  } vexp_t;

  vexp_t       vq[$];
  int          cyc = 0;
  int          m_ack_cycle = -1;
  int          m_rd_cycle = -1;
  int          m_starve = 0;
  bit          m_wait = 1'b0;
  bit          started = 1'b0;
  logic [7:0]  m_vdata = '0;
  logic [7:0]  m_cpu_rdata = '0;
  logic [7:0]  m_rd_val = '0;
  logic [15:0] m_last = '0;

  always @(negedge clk) begin : model
    vexp_t       e;
    vexp_t       n;
    bit          ovr, vg, cg, free;
    logic [15:0] ea;
    cyc++;
    if (reset) begin
      started     = 1'b1;
      m_wait      = 1'b0;
      m_ack_cycle = -1;
      m_rd_cycle  = -1;
      m_starve    = 0;
      m_vdata     = '0;
      m_cpu_rdata = '0;
      m_last      = '0;
      vq.delete();
      e.valid = 1'b0; e.miss = 1'b0; e.data = '0;
      vq.push_back(e);
      vq.push_back(e);
    end else if (started) begin
      e = vq.pop_front();
      if (e.valid) m_vdata = e.data;
      if (cyc == m_rd_cycle) m_cpu_rdata = m_rd_val;
      check("m_vid_valid", vid_valid, e.valid);
      check("m_vid_miss", vid_miss, e.miss);
      check("m_vid_data", vid_data, m_vdata);
      check("m_cpu_ack", cpu_ack, cyc == m_ack_cycle);
      check("m_cpu_rdata", cpu_rdata, m_cpu_rdata);

      ovr  = STARVE && m_wait && (m_starve >= LIMIT);
      vg   = vid_req && !ovr;
      cg   = m_wait && (!vid_req || ovr);
      free = !m_wait && (cyc > m_ack_cycle);
      ea   = vg ? vid_addr : (cg ? cpu_addr : m_last);
      check("m_mem_addr", mem_addr, ea);
      check("m_mem_we", mem_we, cg && cpu_we);
      if (cg && cpu_we) check("m_mem_wdata", mem_wdata, cpu_wdata);

      n.valid = vg;
      n.miss  = vid_req && !vg;
      n.data  = m_ram[vid_addr];
      vq.push_back(n);
      m_last = ea;

      if (cg) begin
        m_wait   = 1'b0;
        m_starve = 0;
        if (cpu_we) begin
          m_ram[cpu_addr] = cpu_wdata;
          m_ack_cycle     = cyc + 1;
        end else begin
          m_rd_val    = m_ram[cpu_addr];
          m_rd_cycle  = cyc + 2;
          m_ack_cycle = cyc + 2;
        end
      end else if (m_wait && STARVE) begin
        m_starve++;
      end
      if (free && cpu_req) m_wait = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef VRAM_CPU_STARVE_EN
  // Continuous video traffic with one CPU read pending; reports when the CPU got through.
  task automatic starve_run(input logic [15:0] addr, output int grant_k, output int ack_k,
                            output int misses, output int miss_k, output logic [7:0] rd);
    bit acked = 1'b0;
    grant_k = -1; ack_k = -1; misses = 0; miss_k = -1; rd = '0;
    tick();
    vid_req = 1'b1; vid_addr = 16'h1100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    @(negedge clk);
    for (int k = 1; k <= 24; k++) begin
      tick();
      vid_addr = 16'h1100 + 16'(k);
      if (acked) cpu_req = 1'b0;
      @(negedge clk);
      if (mem_addr == addr && grant_k < 0) grant_k = k;
      if (vid_miss) begin misses++; miss_k = k; end
      if (cpu_ack && !acked) begin acked = 1'b1; ack_k = k; rd = cpu_rdata; end
    end
    tick();
    vid_req = 1'b0; cpu_req = 1'b0;
  endtask
`endif

  initial begin : stim
    int g_cnt, a_cnt, g1, g2, a1, a2, n_acks, n_miss, gk, ak, mk, mkk;
    logic [7:0] rd;
    int n;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_vid_valid", vid_valid, 1'b0);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_vid_data", vid_data, 8'h00);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);

    // Back-to-back video fetches 0x1000..0x1007.
    for (int i = 0; i < 10; i++) begin
      tick();
      vid_req  = (i < 8);
      vid_addr = 16'h1000 + 16'(i);
      @(negedge clk);
      if (i >= 2) begin
        check("seq_vid_valid", vid_valid, 1'b1);
        check("seq_vid_data", vid_data, 16'(i - 2));
      end else begin
        check("seq_vid_valid_early", vid_valid, 1'b0);
      end
    end
    tick();
    vid_req = 1'b0;
    @(negedge clk);
    check("seq_vid_valid_end", vid_valid, 1'b0);

    // CPU write 0x55 -> 0x2000, then read it back.
    tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h55;
    @(negedge clk); check("wr_ack_c0", cpu_ack, 1'b0);
    tick(); @(negedge clk);
    check("wr_grant_we", mem_we, 1'b1);
    check("wr_grant_addr", mem_addr, 16'h2000);
    check("wr_grant_wdata", mem_wdata, 8'h55);
    tick(); @(negedge clk); check("wr_ack", cpu_ack, 1'b1);
    tick(); cpu_req = 1'b0; @(negedge clk); check("wr_ack_done", cpu_ack, 1'b0);
    tick(); cpu_req = 1'b1; cpu_we = 1'b0;
    tick(); @(negedge clk);
    check("rd_grant_we", mem_we, 1'b0);
    check("rd_grant_addr", mem_addr, 16'h2000);
    tick(); @(negedge clk); check("rd_ack_early", cpu_ack, 1'b0);
    tick(); @(negedge clk);
    check("rd_ack", cpu_ack, 1'b1);
    check("rd_data", cpu_rdata, 8'h55);
    tick(); cpu_req = 1'b0;

    // cpu_req held across two writes: grants at k=1 and k=4, acks at k=2 and k=5.
    g_cnt = 0; a_cnt = 0; g1 = -1; g2 = -1; a1 = -1; a2 = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2100; cpu_wdata = 8'hA1; end
      if (k == 3) begin cpu_addr = 16'h2101; cpu_wdata = 8'hB2; end
      if (k == 6) cpu_req = 1'b0;
      @(negedge clk);
      if (mem_we) begin g_cnt++; if (g1 < 0) g1 = k; else g2 = k; end
      if (cpu_ack) begin a_cnt++; if (a1 < 0) a1 = k; else a2 = k; end
    end
    check("dbl_grant_count", 16'(g_cnt), 16'd2);
    check("dbl_grant1_cycle", 16'(g1), 16'd1);
    check("dbl_grant2_cycle", 16'(g2), 16'd4);
    check("dbl_ack_count", 16'(a_cnt), 16'd2);
    check("dbl_ack1_cycle", 16'(a1), 16'd2);
    check("dbl_ack2_cycle", 16'(a2), 16'd5);

`ifdef VRAM_CPU_STARVE_EN
    // Read waits 8 denied cycles, wins on the 9th; miss and ack land two cycles later.
    for (int r = 0; r < 2; r++) begin
      starve_run(16'h1004 + 16'(r), gk, ak, mk, mkk, rd);
      check("stv_grant_cycle", 16'(gk), 16'd9);
      check("stv_ack_cycle", 16'(ak), 16'd11);
      check("stv_miss_count", 16'(mk), 16'd1);
      check("stv_miss_cycle", 16'(mkk), 16'd11);
      check("stv_rdata", rd, 8'h04 + 8'(r));
    end
`else
    // Strict video priority: CPU read starves until vid_req drops.
    n_acks = 0; n_miss = 0; gk = 0;
    tick();
    vid_req = 1'b1; vid_addr = 16'h1100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1003;
    for (int k = 1; k <= 100; k++) begin
      tick();
      vid_addr = 16'h1100 + 16'(k);
      @(negedge clk);
      if (cpu_ack) n_acks++;
      if (vid_miss) n_miss++;
      if (mem_addr == 16'h1003) gk++;
    end
    check("prio_no_ack", 16'(n_acks), 16'd0);
    check("prio_no_miss", 16'(n_miss), 16'd0);
    check("prio_no_grant", 16'(gk), 16'd0);
    tick(); vid_req = 1'b0;
    @(negedge clk);
    check("prio_grant_addr", mem_addr, 16'h1003);
    check("prio_grant_we", mem_we, 1'b0);
    tick(); tick(); @(negedge clk);
    check("prio_ack", cpu_ack, 1'b1);
    check("prio_rdata", cpu_rdata, 8'h03);
    tick(); cpu_req = 1'b0;
`endif

    // Mixed traffic: video every cycle but one in four, CPU alternating writes and reads.
    n = 1;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000 + 16'(n); cpu_wdata = 8'(n * 7);
    for (int k = 0; k < 48; k++) begin
      vid_req  = (k % 4 != 3);
      vid_addr = 16'h3000 + 16'(k);
      @(negedge clk);
      rd = {7'd0, cpu_ack};
      tick();
      if (rd[0]) begin
        n++;
        cpu_we = ~cpu_we; cpu_addr = 16'h2000 + 16'(n / 2); cpu_wdata = 8'(n * 7);
      end
    end
    vid_req = 1'b0;
    // Let any open CPU transaction finish before dropping the request.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rd = {7'd0, cpu_ack};
      tick();
      if (rd[0]) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    repeat (3) tick();

    // Reset in the RDATA cycle of a read: no ack afterwards, all outputs at reset values.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    tick();
    tick(); reset = 1'b1; cpu_req = 1'b0;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("mrst_vid_valid", vid_valid, 1'b0);
    check("mrst_vid_miss", vid_miss, 1'b0);
    check("mrst_cpu_ack", cpu_ack, 1'b0);
    check("mrst_vid_data", vid_data, 8'h00);
    check("mrst_cpu_rdata", cpu_rdata, 8'h00);
    check("mrst_mem_we", mem_we, 1'b0);
    check("mrst_mem_addr", mem_addr, 16'h0000);
    n_acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge clk);
      if (cpu_ack) n_acks++;
    end
    check("mrst_no_late_ack", 16'(n_acks), 16'd0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
